cpu_wb_arbiter: RTL and testbench

- Writeback arbiter and scoreboard in front of the CPU register file's single write port.
- Shares that port round-robin among NREQ writeback sources (ALU, load unit, mul/div), with a valid/ready handshake.
- Registers the winning write into a one-stage output register.
- Tracks in-flight destination registers so issue logic can stall on RAW/WAW hazards.

---
 rtl/cpu_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_cpu_wb_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_wb_arbiter.sv
// Round-robin writeback arbiter with a one-stage register-file write register and a destination scoreboard.
// Define WB_BYPASS_EN to forward the value in the output stage to the issue-stage source operands.
module cpu_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*5-1:0]  req_rd_addr,
  input  logic [NREQ*XLEN-1:0] req_rd_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [4:0]         rd_addr,
  output logic [XLEN-1:0]    rd_data,
  output logic               rd_write_en,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd_addr,
  output logic               issue_ready,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  output logic               hazard_rs1,
  output logic               hazard_rs2,
  output logic               fwd_rs1_valid,
  output logic               fwd_rs2_valid,
  output logic [XLEN-1:0]    fwd_rs1_data,
  output logic [XLEN-1:0]    fwd_rs2_data,
  output logic [31:0]        busy_mask
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   grant_idx;
  logic [PW:0]     scan_sum;
  logic [PW-1:0]   scan_idx;
  logic            grant_any;
  logic [NREQ-1:0] grant;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic [31:0]     clr_vec;
  logic [31:0]     set_vec;
  logic            alloc;

  // Handshake: a requester holds valid/addr/data until ready; a transfer happens in any
  // cycle where valid && ready, and ready never waits on the output stage.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) scan_sum = scan_sum - (PW+1)'(NREQ);
      scan_idx = scan_sum[PW-1:0];
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
    if (reset) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_rd_addr[5*i +: 5];
        sel_data = req_rd_data[XLEN*i +: XLEN];
      end
    end
  end

  assign req_ready = grant;
  assign ptr_next  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

  // A register being written this cycle may be re-allocated; the set below wins over the clear.
  assign issue_ready = (issue_rd_addr == 5'd0) || !busy[issue_rd_addr] ||
                       (rd_write_en && (rd_addr == issue_rd_addr));
  assign alloc     = issue_valid && issue_ready && (issue_rd_addr != 5'd0);
  assign clr_vec   = rd_write_en ? (32'd1 << rd_addr) : 32'd0;
  assign set_vec   = alloc ? (32'd1 << issue_rd_addr) : 32'd0;
  assign busy_next = ((busy & ~clr_vec) | set_vec) & ~32'd1;
  assign busy_mask = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      rd_write_en <= 1'b0;
      rd_addr     <= '0;
      rd_data     <= '0;
      busy        <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr  <= ptr_next;
        rd_addr <= sel_addr;
        rd_data <= sel_data;
      end
      rd_write_en <= grant_any && (sel_addr != 5'd0);
      busy        <= busy_next;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_rs1_valid = rd_write_en && (rd_addr == rs1_addr) && (rs1_addr != 5'd0);
  assign fwd_rs2_valid = rd_write_en && (rd_addr == rs2_addr) && (rs2_addr != 5'd0);
  assign fwd_rs1_data  = fwd_rs1_valid ? rd_data : '0;
  assign fwd_rs2_data  = fwd_rs2_valid ? rd_data : '0;
  assign hazard_rs1    = busy[rs1_addr] && !fwd_rs1_valid;
  assign hazard_rs2    = busy[rs2_addr] && !fwd_rs2_valid;
`else
  assign fwd_rs1_valid = 1'b0;
  assign fwd_rs2_valid = 1'b0;
  assign fwd_rs1_data  = '0;
  assign fwd_rs2_data  = '0;
  assign hazard_rs1    = busy[rs1_addr];
  assign hazard_rs2    = busy[rs2_addr];
`endif

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Self-checking bench for cpu_wb_arbiter: directed scenarios then randomized traffic against a behavioural model.
module tb_cpu_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREQ = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd_addr;
  logic [NREQ*XLEN-1:0] req_rd_data;
  logic [NREQ-1:0]      req_ready;
  logic [4:0]           rd_addr;
  logic [XLEN-1:0]      rd_data;
  logic                 rd_write_en;
  logic                 issue_valid;
  logic [4:0]           issue_rd_addr;
  logic                 issue_ready;
  logic [4:0]           rs1_addr, rs2_addr;
  logic                 hazard_rs1, hazard_rs2;
  logic                 fwd_rs1_valid, fwd_rs2_valid;
  logic [XLEN-1:0]      fwd_rs1_data, fwd_rs2_data;
  logic [31:0]          busy_mask;

  int checks = 0;
  int errors = 0;

  // behavioural model state for the randomized phase
  int              m_ptr;
  bit [31:0]       m_busy;
  bit              m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  bit              pend[NREQ];
  logic [4:0]      paddr[NREQ];
  logic [XLEN-1:0] pdata[NREQ];
  logic [NREQ-1:0] last_grant;

  always #5 clk = ~clk;

  cpu_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd_addr(req_rd_addr), .req_rd_data(req_rd_data),
    .req_ready(req_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
    .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .fwd_rs1_valid(fwd_rs1_valid), .fwd_rs2_valid(fwd_rs2_valid),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .busy_mask(busy_mask)
  );

  task automatic idle_inputs();
    req_valid     = '0;
    req_rd_addr   = '0;
    req_rd_data   = '0;
    issue_valid   = 1'b0;
    issue_rd_addr = '0;
    rs1_addr      = '0;
    rs2_addr      = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [XLEN-1:0] d);
    req_valid[i]                = 1'b1;
    req_rd_addr[5*i +: 5]       = a;
    req_rd_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
    checks++; if (rd_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", rd_write_en); end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_mask); end
    checks++; if (rd_addr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL reset_out: got %0d/%h exp 0/0", rd_addr, rd_data); end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    issue_valid = 1'b1; issue_rd_addr = 5'd5;
    set_req(1, 5'd3, 32'h11);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rst_pre_ready: got %b exp 010", req_ready); end
    @(negedge clk);
    idle_inputs();
    rs1_addr = 5'd5;
    set_req(0, 5'd1, 32'h1);
    set_req(2, 5'd2, 32'h2);
    #1;
    checks++; if (rd_write_en !== 1'b1) begin errors++; $display("FAIL rst_mid_we: got %b exp 1", rd_write_en); end
    checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL rst_mid_busy: got %h exp 20", busy_mask); end
    checks++; if (hazard_rs1 !== 1'b1) begin errors++; $display("FAIL rst_mid_haz: got %b exp 1", hazard_rs1); end
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rst_mid_ready: got %b exp 100", req_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rd_write_en !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %b exp 0", rd_write_en); end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL rst_async_busy: got %h exp 0", busy_mask); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_async_ready: got %b exp 000", req_ready); end
    checks++; if (hazard_rs1 !== 1'b0) begin errors++; $display("FAIL rst_async_haz: got %b exp 0", hazard_rs1); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rst_ptr_ready: got %b exp 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_r;
    logic [4:0]  ea;
    logic [31:0] ed;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'hA0 + 32'(i));
      end
      #1;
      exp_r = 3'b001 << (c % 3);
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready c%0d: got %b exp %b", c, req_ready, exp_r); end
      if (c == 0) begin
        checks++; if (rd_write_en !== 1'b0) begin errors++; $display("FAIL rr_we0: got %b exp 0", rd_write_en); end
      end else begin
        ea = 5'(10 + (c - 1) % 3);
        ed = 32'hA0 + 32'((c - 1) % 3);
        checks++; if (rd_write_en !== 1'b1 || rd_addr !== ea || rd_data !== ed) begin
          errors++; $display("FAIL rr_out c%0d: got %b/%0d/%h exp 1/%0d/%h", c, rd_write_en, rd_addr, rd_data, ea, ed);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd_write_en !== 1'b1 || rd_addr !== 5'd12 || rd_data !== 32'hA2) begin
      errors++; $display("FAIL rr_last: got %b/%0d/%h exp 1/12/a2", rd_write_en, rd_addr, rd_data);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    idle_inputs();
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL lat_ready: got %b exp 010", req_ready); end
    checks++; if (rd_write_en !== 1'b0) begin errors++; $display("FAIL lat_we_n: got %b exp 0", rd_write_en); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd_write_en !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat_out: got %b/%0d/%h exp 1/5/deadbeef", rd_write_en, rd_addr, rd_data);
    end
    @(negedge clk);
    #1;
    checks++; if (rd_write_en !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat_hold: got %b/%0d/%h exp 0/5/deadbeef", rd_write_en, rd_addr, rd_data);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle_inputs();
    set_req(0, 5'd0, 32'h1234);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready_wrap: got %b exp 001", req_ready); end
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_rd_addr = 5'd0;
    #1;
    checks++; if (rd_write_en !== 1'b0) begin errors++; $display("FAIL x0_we: got %b exp 0", rd_write_en); end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL x0_busy: got %h exp 0", busy_mask); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready: got %b exp 1", issue_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL x0_busy_after: got %h exp 0", busy_mask); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_rd_addr = 5'd7;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue1: got %b exp 1", issue_ready); end
    @(negedge clk);
    rs1_addr = 5'd7;
    #1;
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_busy_set: got %h exp 80", busy_mask); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_waw: got %b exp 0", issue_ready); end
    checks++; if (hazard_rs1 !== 1'b1 || hazard_rs2 !== 1'b0) begin errors++; $display("FAIL sb_hazard: got %b%b exp 10", hazard_rs1, hazard_rs2); end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 5'd7, 32'h77);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL sb_ready: got %b exp 010", req_ready); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_busy_hold: got %h exp 80", busy_mask); end
    @(negedge clk);
    idle_inputs();
    rs1_addr = 5'd7;
    #1;
    checks++; if (rd_write_en !== 1'b1 || rd_addr !== 5'd7) begin errors++; $display("FAIL sb_wb: got %b/%0d exp 1/7", rd_write_en, rd_addr); end
    checks++; if (hazard_rs1 !== !BYP) begin errors++; $display("FAIL sb_wb_haz: got %b exp %b", hazard_rs1, !BYP); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL sb_busy_clr: got %h exp 0", busy_mask); end
    @(negedge clk);
    issue_valid = 1'b1; issue_rd_addr = 5'd7;
    @(negedge clk);
    idle_inputs();
    set_req(0, 5'd7, 32'h78);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL sb_ready2: got %b exp 001", req_ready); end
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_rd_addr = 5'd7;
    #1;
    checks++; if (rd_write_en !== 1'b1 || rd_addr !== 5'd7) begin errors++; $display("FAIL sb_wb2: got %b/%0d exp 1/7", rd_write_en, rd_addr); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_reissue_ready: got %b exp 1", issue_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_set_wins: got %h exp 80", busy_mask); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_rd_addr = 5'd9;
    @(negedge clk);
    idle_inputs();
    set_req(1, 5'd9, 32'h55);
    @(negedge clk);
    idle_inputs();
    rs1_addr = 5'd7; rs2_addr = 5'd9;
    #1;
    checks++; if (rd_write_en !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h55) begin
      errors++; $display("FAIL byp_out: got %b/%0d/%h exp 1/9/55", rd_write_en, rd_addr, rd_data);
    end
    checks++; if (fwd_rs2_valid !== BYP || fwd_rs2_data !== (BYP ? 32'h55 : 32'h0)) begin
      errors++; $display("FAIL byp_fwd2: got %b/%h exp %b/%h", fwd_rs2_valid, fwd_rs2_data, BYP, BYP ? 32'h55 : 32'h0);
    end
    checks++; if (hazard_rs2 !== !BYP) begin errors++; $display("FAIL byp_haz2: got %b exp %b", hazard_rs2, !BYP); end
    checks++; if (fwd_rs1_valid !== 1'b0 || hazard_rs1 !== 1'b1) begin
      errors++; $display("FAIL byp_rs1: got fwd %b haz %b exp 0/1", fwd_rs1_valid, hazard_rs1);
    end
  endtask

  task automatic test_random();
    int          exp_g;
    int          idx;
    logic [2:0]  exp_ready;
    bit          exp_ir, f1, f2, h1, h2;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0; m_busy = '0; m_we = 1'b0; m_addr = '0; m_data = '0; last_grant = '0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; end
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant[i]) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            pend[i] = 1'b1; paddr[i] = 5'($urandom_range(7, 0)); pdata[i] = $urandom;
          end
        end else if ($urandom_range(15, 0) == 0) begin
          pend[i] = 1'b0;
        end
        req_valid[i] = pend[i];
        req_rd_addr[5*i +: 5] = paddr[i];
        req_rd_data[XLEN*i +: XLEN] = pdata[i];
      end
      issue_valid   = 1'($urandom_range(1, 0));
      issue_rd_addr = 5'($urandom_range(7, 0));
      rs1_addr      = 5'($urandom_range(7, 0));
      rs2_addr      = 5'($urandom_range(7, 0));
      exp_g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (exp_g < 0 && pend[idx]) exp_g = idx;
      end
      exp_ready = (exp_g >= 0) ? (3'b001 << exp_g) : 3'b000;
      exp_ir = (issue_rd_addr == 0) || !m_busy[issue_rd_addr] || (m_we && m_addr == issue_rd_addr);
      f1 = BYP && m_we && m_addr == rs1_addr && rs1_addr != 0;
      f2 = BYP && m_we && m_addr == rs2_addr && rs2_addr != 0;
      h1 = m_busy[rs1_addr] && !f1;
      h2 = m_busy[rs2_addr] && !f2;
      #1;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b exp %b", cyc, req_ready, exp_ready); end
      checks++; if (rd_write_en !== m_we) begin errors++; $display("FAIL rnd_we cyc%0d: got %b exp %b", cyc, rd_write_en, m_we); end
      if (m_we) begin
        checks++; if (rd_addr !== m_addr || rd_data !== m_data) begin
          errors++; $display("FAIL rnd_out cyc%0d: got %0d/%h exp %0d/%h", cyc, rd_addr, rd_data, m_addr, m_data);
        end
        if (f2) begin
          checks++; if (fwd_rs2_data !== m_data) begin errors++; $display("FAIL rnd_fwd2_data cyc%0d: got %h exp %h", cyc, fwd_rs2_data, m_data); end
        end
      end
      checks++; if (busy_mask !== m_busy) begin errors++; $display("FAIL rnd_busy cyc%0d: got %h exp %h", cyc, busy_mask, m_busy); end
      checks++; if (issue_ready !== exp_ir) begin errors++; $display("FAIL rnd_issue_ready cyc%0d: got %b exp %b", cyc, issue_ready, exp_ir); end
      checks++; if (hazard_rs1 !== h1 || hazard_rs2 !== h2) begin errors++; $display("FAIL rnd_hazard cyc%0d: got %b%b exp %b%b", cyc, hazard_rs1, hazard_rs2, h1, h2); end
      checks++; if (fwd_rs1_valid !== f1 || fwd_rs2_valid !== f2) begin errors++; $display("FAIL rnd_fwd cyc%0d: got %b%b exp %b%b", cyc, fwd_rs1_valid, fwd_rs2_valid, f1, f2); end
      last_grant = exp_ready;
      if (m_we) m_busy[m_addr] = 1'b0;
      if (issue_valid && exp_ir && issue_rd_addr != 0) m_busy[issue_rd_addr] = 1'b1;
      if (exp_g >= 0) begin
        m_ptr = (exp_g + 1) % NREQ;
        m_we = (paddr[exp_g] != 0); m_addr = paddr[exp_g]; m_data = pdata[exp_g];
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_latency();
    test_x0();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
